write_enable_multi: RTL

//  Multi-channel, multi-mode successor of the single-channel BRAM write-enable controller.

---
 rtl/write_enable_multi_if.sv | 30 +++
 rtl/write_enable_multi.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/write_enable_multi_if.sv
// Bus bundle between the sweep source/control side and write_enable_multi.
// The master side supplies the sweep address and acquisition configuration.
// The slave side (the controller) returns the write enables and status.
interface write_enable_multi_if #(
  parameter int BRAM_WIDTH  = 5,
  parameter int COUNT_WIDTH = 16,
  parameter int N_CH        = 2
);
  logic                   restart;
  logic                   mode;
  logic [N_CH-1:0]        ch_en;
  logic [BRAM_WIDTH-1:0]  address;
  logic [BRAM_WIDTH-1:0]  addr_max;
  logic [COUNT_WIDTH-1:0] count_max;
  logic [N_CH-1:0]        wen;
  logic                   init;
  logic [COUNT_WIDTH-1:0] count;
  logic                   busy;
  logic                   done;

  modport master (
    output restart, mode, ch_en, address, addr_max, count_max,
    input  wen, init, count, busy, done
  );

  modport slave (
    input  restart, mode, ch_en, address, addr_max, count_max,
    output wen, init, count, busy, done
  );
endinterface

// File: rtl/write_enable_multi.sv
// Multi-channel BRAM write-enable controller.
// After a restart it waits for a sweep boundary, then enables the selected
// channels for count_max+1 full sweeps, flagging the first sweep with init so
// the accumulators overwrite instead of adding. Single-shot or continuous.
module write_enable_multi #(
  parameter int BRAM_WIDTH  = 5,
  parameter int COUNT_WIDTH = 16,
  parameter int N_CH        = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  write_enable_multi_if.slave       bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    ACQ  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  // Configuration captured on restart, held for the whole acquisition.
  logic                   r_mode_l;
  logic [N_CH-1:0]        r_ch_en_l;
  logic [COUNT_WIDTH-1:0] r_count_max_l;
  logic                   w_mode_nxt;
  logic [N_CH-1:0]        w_ch_en_nxt;
  logic [COUNT_WIDTH-1:0] w_count_max_nxt;

  // Registered outputs and their next values.
  logic [N_CH-1:0]        r_wen;
  logic                   r_init;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   r_busy;
  logic                   r_done;
  logic [N_CH-1:0]        w_wen_nxt;
  logic                   w_init_nxt;
  logic [COUNT_WIDTH-1:0] w_count_nxt;
  logic                   w_done_nxt;

  logic                   w_end;
  logic                   w_last_sweep;

  // Sweep counter increment; wraps naturally modulo 2^COUNT_WIDTH.
  function automatic logic [COUNT_WIDTH-1:0] f_count_inc(
    input logic [COUNT_WIDTH-1:0] val
  );
    return val + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // A sweep ends on the cycle its last address is presented.
  assign w_end        = (bus.address == bus.addr_max);
  assign w_last_sweep = (r_count == r_count_max_l);

  // State register; reset drops straight back to IDLE even mid-acquisition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output decode. A restart always wins over any sweep
  // boundary event, so a re-arm never emits a done pulse.
  always_comb begin
    w_state_nxt     = r_state;
    w_mode_nxt      = r_mode_l;
    w_ch_en_nxt     = r_ch_en_l;
    w_count_max_nxt = r_count_max_l;
    w_wen_nxt       = r_wen;
    w_init_nxt      = r_init;
    w_count_nxt     = r_count;
    w_done_nxt      = 1'b0;

    if (bus.restart) begin
      w_mode_nxt      = bus.mode;
      w_ch_en_nxt     = bus.ch_en;
      w_count_max_nxt = bus.count_max;
      w_wen_nxt       = '0;
      w_init_nxt      = 1'b0;
      w_count_nxt     = '0;
      w_state_nxt     = ARM;
    end else begin
      case (r_state)
        IDLE: begin
          w_wen_nxt  = '0;
          w_init_nxt = 1'b0;
        end

        // Wait for a sweep boundary so the first enabled cycle is address 0.
        ARM: begin
          if (w_end) begin
            w_state_nxt = ACQ;
            w_wen_nxt   = r_ch_en_l;
            w_init_nxt  = 1'b1;
          end
        end

        ACQ: begin
          w_wen_nxt = r_ch_en_l;
          if (w_end) begin
            if (w_last_sweep) begin
              w_done_nxt = 1'b1;
              if (r_mode_l) begin
                // Continuous: the next acquisition starts immediately and
                // its first sweep overwrites again.
                w_count_nxt = '0;
                w_init_nxt  = 1'b1;
              end else begin
                w_count_nxt = f_count_inc(r_count);
                w_wen_nxt   = '0;
                w_init_nxt  = 1'b0;
                w_state_nxt = IDLE;
              end
            end else begin
              w_count_nxt = f_count_inc(r_count);
              w_init_nxt  = 1'b0;
            end
          end
        end

        default: begin
          w_state_nxt = IDLE;
          w_wen_nxt   = '0;
          w_init_nxt  = 1'b0;
        end
      endcase
    end
  end

  // Latched configuration; cleared by reset so a stale mask cannot leak.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode_l      <= 1'b0;
      r_ch_en_l     <= '0;
      r_count_max_l <= '0;
    end else begin
      r_mode_l      <= w_mode_nxt;
      r_ch_en_l     <= w_ch_en_nxt;
      r_count_max_l <= w_count_max_nxt;
    end
  end

  // Output registers; busy tracks the state being entered so it is glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wen   <= '0;
      r_init  <= 1'b0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_wen   <= w_wen_nxt;
      r_init  <= w_init_nxt;
      r_count <= w_count_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= w_done_nxt;
    end
  end

  assign bus.wen   = r_wen;
  assign bus.init  = r_init;
  assign bus.count = r_count;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;

endmodule
